lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//   MEM-stage load/store sequencer. Decodes the MEM-stage instruction and checks alignment.
//   Drives a req/ack data-memory port with word address, byte enables and lane-replicated store data.
//   Stalls the pipeline until the access completes and hands raw load word + byte offset to the
//   WB-stage load-extension unit. Non-memory instructions pass through with no stall.
// PARAMETERS
//   MAX_WAIT  15  cycles in ACCESS without mem_ack before bus error (LSU_TIMEOUT_EN only), 1..255
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high
//   req_valid  in   1   MEM stage holds a valid instruction
//   ir_m       in   32  MEM-stage instruction; opcode = ir_m[31:26]
//   addr       in   32  effective address
//   wdata      in   32  store source register value
//   stall      out  1   freeze IF..MEM stages (combinational)
//   mem_req    out  1   memory request, held until ack
//   mem_we     out  1   1 = store
//   mem_be     out  4   byte enables, bit i = byte lane i
//   mem_addr   out  32  {addr[31:2],2'b00}, registered
//   mem_wdata  out  32  lane-aligned store data, registered
//   mem_ack    in   1   one-cycle completion strobe
//   mem_rdata  in   32  read word, valid with mem_ack
//   ld_data    out  32  captured raw load word
//   ld_offset  out  2   addr[1:0] of completed load (extension-unit OFFSET)
//   ld_valid   out  1   one-cycle pulse: load complete
//   adel/ades  out  1   one-cycle pulse: misaligned load/store, no memory access issued
//   bus_err    out  1   one-cycle pulse: timeout
// BEHAVIOUR
//   Opcodes: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011.
//   Reset: state IDLE; mem_req/mem_we/ld_valid/adel/ades/bus_err = 0; mem_be = 0; addr/data regs = 0.
//   Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0. Byte ops are never misaligned.
//   FSM IDLE -> ACCESS -> DONE -> IDLE; ACCESS -> ERR -> IDLE on timeout.
//   IDLE: req_valid & aligned mem op -> latch request, mem_req=1 next cycle, goto ACCESS.
//         req_valid & misaligned -> adel (load) / ades (store) pulse next cycle, stay IDLE, no stall.
//         non-memory opcode or !req_valid -> nothing.
//   ACCESS: mem_req held with stable addr/be/data. On mem_ack: mem_req=0, ld_data<=mem_rdata
//         (loads only), goto DONE. An ack arriving in the first ACCESS cycle is accepted.
//   DONE: ld_valid=1 for loads (0 for stores); stall=0 so pipeline advances; req_valid ignored; goto IDLE.
//   ERR: bus_err=1, stall=0, mem_req=0, goto IDLE.
//   stall = (IDLE & req_valid & aligned mem op) | ACCESS. Minimum latency: 2 stall cycles.
//   Store lanes: sb be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; sh be=addr[1]?4'b1100:4'b0011,
//         wdata={2{wdata[15:0]}}; sw be=4'b1111, wdata unchanged. Loads: mem_we=0, be=4'b1111.
//   mem_ack outside ACCESS is ignored. Reset mid-access drops mem_req next edge; stale ack ignored.
//   ld_data/ld_offset hold until next completed load.
// CONFIGURATION
//   LSU_TIMEOUT_EN defined: 8-bit wait counter, cleared on entry to ACCESS, increments each
//     ACCESS cycle without ack; when equal to MAX_WAIT -> ERR.
//   LSU_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, bus_err tied 0, ERR unreachable.
// TESTING
//   lw addr=0x1000, ack 3 cycles after req, rdata=0xDEADBEEF -> mem_addr=0x1000, be=1111,
//     stall for 4 cycles, ld_valid pulse, ld_data=0xDEADBEEF, ld_offset=0.
//   sb addr=0x2003 wdata=0x000000A5, immediate ack -> be=1000, mem_wdata=0xA5A5A5A5, mem_we=1,
//     ld_valid=0, 2 stall cycles.
//   sh addr=0x2002 wdata=0x1234 -> be=1100, mem_wdata=0x12341234; sh addr=0x2001 -> ades pulse,
//     mem_req never rises, stall=0.
//   lhu addr=0x3002 -> mem_addr=0x3000, ld_offset=2'b10; lw addr=0x3001 -> adel pulse, no access.
//   LSU_TIMEOUT_EN, MAX_WAIT=15, ack never -> bus_err pulse after 15 ACCESS cycles, mem_req drops,
//     FSM back in IDLE.
//   reset asserted during ACCESS then ack next cycle -> mem_req=0, stall=0, ld_valid stays 0.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Data-memory port of the MEM-stage load/store sequencer: req/ack handshake,
// word address, byte enables and lane-replicated write data.
interface lsu_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: decode, alignment check, req/ack memory access, stall.
// Optional access timeout with bus error is built when LSU_TIMEOUT_EN is defined.
module lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [31:0]       ir_m,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  lsu_ctrl_if.master        mem,
  output logic [31:0]       ld_data,
  output logic [1:0]        ld_offset,
  output logic              ld_valid,
  output logic              adel,
  output logic              ades,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state;
  size_t       size;
  logic [5:0]  opcode;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic        load_q;
  logic [1:0]  off_q;
  logic        unused_ir;

`ifdef LSU_TIMEOUT_EN
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_nxt;
  assign wait_nxt = wait_cnt + 8'd1;
`endif

  assign opcode    = ir_m[31:26];
  assign unused_ir = ^ir_m[25:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_W;
    case (opcode)
      6'b100000, 6'b100100: begin is_load  = 1'b1; size = SZ_B; end
      6'b100001, 6'b100101: begin is_load  = 1'b1; size = SZ_H; end
      6'b100011:            begin is_load  = 1'b1; size = SZ_W; end
      6'b101000:            begin is_store = 1'b1; size = SZ_B; end
      6'b101001:            begin is_store = 1'b1; size = SZ_H; end
      6'b101011:            begin is_store = 1'b1; size = SZ_W; end
      default: ;
    endcase
    is_mem = is_load | is_store;

    case (size)
      SZ_B: begin
        misaligned = 1'b0;
        be_c       = 4'b0001 << addr[1:0];
        wd_c       = {4{wdata[7:0]}};
      end
      SZ_H: begin
        misaligned = addr[0];
        be_c       = addr[1] ? 4'b1100 : 4'b0011;
        wd_c       = {2{wdata[15:0]}};
      end
      default: begin
        misaligned = (addr[1:0] != 2'b00);
        be_c       = 4'b1111;
        wd_c       = wdata;
      end
    endcase

    // Loads always fetch the full word; the WB extension unit picks the lane.
    if (is_load) begin
      be_c = 4'b1111;
      wd_c = '0;
    end
  end

  always_comb begin
    stall = (state == ACCESS) ||
            ((state == IDLE) && req_valid && is_mem && !misaligned);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      ld_data       <= '0;
      ld_offset     <= '0;
      ld_valid      <= 1'b0;
      adel          <= 1'b0;
      ades          <= 1'b0;
      bus_err       <= 1'b0;
      load_q        <= 1'b0;
      off_q         <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      ld_valid <= 1'b0;
      adel     <= 1'b0;
      ades     <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && is_mem) begin
            if (misaligned) begin
              adel <= is_load;
              ades <= is_store;
            end else begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= is_store;
              mem.mem_be    <= be_c;
              mem.mem_addr  <= {addr[31:2], 2'b00};
              mem.mem_wdata <= wd_c;
              load_q        <= is_load;
              off_q         <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
              wait_cnt      <= '0;
`endif
              state         <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (load_q) begin
              ld_data   <= mem.mem_rdata;
              ld_offset <= off_q;
            end
            ld_valid <= load_q;
            state    <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_nxt == 8'(MAX_WAIT)) begin
            mem.mem_req <= 1'b0;
            bus_err     <= 1'b1;
            state       <= ERR;
          end else begin
            wait_cnt <= wait_nxt;
          end
`endif
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed instructions push expected memory
// requests / load results / exceptions; a negedge monitor pops and compares.
module tb_lsu_ctrl;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_ADD = 6'b000000;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  off;
  } ld_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] ir_m;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic [1:0]  ld_offset;
  logic        ld_valid;
  logic        adel;
  logic        ades;
  logic        bus_err;

  lsu_ctrl_if bus();

  logic        model_ack;
  logic        stale_ack;
  logic [31:0] rdata_drv;
  int          ack_after;
  int          acc_cnt;

  assign bus.mem_ack   = model_ack | stale_ack;
  assign bus.mem_rdata = rdata_drv;

  lsu_ctrl #(.MAX_WAIT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .ir_m      (ir_m),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .mem       (bus),
    .ld_data   (ld_data),
    .ld_offset (ld_offset),
    .ld_valid  (ld_valid),
    .adel      (adel),
    .ades      (ades),
    .bus_err   (bus_err)
  );

  int          checks = 0;
  int          errors = 0;
  req_t        q_req[$];
  ld_t         q_ld[$];
  logic [1:0]  q_exc[$];
  int          q_berr = 0;
  logic [31:0] last_ld = '0;
  logic [31:0] rd_next = '0;
  logic        prev_req = 1'b0;
  req_t        cur;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Memory model: acks in the ack_after-th ACCESS cycle (0 = never).
  initial begin
    model_ack = 1'b0;
    rdata_drv = '0;
    acc_cnt   = 0;
    forever begin
      @(posedge clk); #1;
      model_ack = 1'b0;
      if (bus.mem_req && !reset) begin
        acc_cnt++;
        if (ack_after != 0 && acc_cnt == ack_after) begin
          model_ack = 1'b1;
          rdata_drv = rd_next;
        end
      end else begin
        acc_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_req && !prev_req) begin
        if (q_req.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
        end else begin
          cur = q_req.pop_front();
          chk("mem_addr", bus.mem_addr, cur.a);
          chk("mem_be", {28'd0, bus.mem_be}, {28'd0, cur.be});
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, cur.we});
          if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wd);
        end
      end else if (bus.mem_req) begin
        chk("req_stable", {bus.mem_addr[31:4], bus.mem_be}, {cur.a[31:4], cur.be});
      end
      if (ld_valid) begin
        if (q_ld.size() == 0) begin
          chk("unexpected_ld_valid", 32'd1, 32'd0);
        end else begin
          ld_t l;
          l = q_ld.pop_front();
          chk("ld_data", ld_data, l.d);
          chk("ld_offset", {30'd0, ld_offset}, {30'd0, l.off});
        end
      end
      if (adel || ades) begin
        if (q_exc.size() == 0) begin
          chk("unexpected_addr_exc", {30'd0, adel, ades}, 32'd0);
        end else begin
          chk("addr_exc", {30'd0, adel, ades}, {30'd0, q_exc.pop_front()});
        end
      end
      if (bus_err) begin
        chk("bus_err_expected", 32'(q_berr > 0), 32'd1);
        if (q_berr > 0) q_berr--;
      end
    end
    prev_req = bus.mem_req;
  end

  task automatic expect_req(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    req_t r;
    r.a = a; r.be = be; r.we = we; r.wd = wd;
    q_req.push_back(r);
  endtask

  task automatic expect_ld(input logic [31:0] d, input logic [1:0] off);
    ld_t l;
    l.d = d; l.off = off;
    q_ld.push_back(l);
    last_ld = d;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int ackc, input logic [31:0] rd, input int exp_stall);
    int  n;
    bit  done;
    @(posedge clk); #1;
    ack_after = ackc;
    rd_next   = rd;
    req_valid = 1'b1;
    ir_m      = {op, 26'h0};
    addr      = a;
    wdata     = wd;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (stall) n++;
      else done = 1'b1;
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    if (!done) chk("stall_released", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ir_m      = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    ir_m      = '0;
    addr      = '0;
    wdata     = '0;
    stale_ack = 1'b0;
    ack_after = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_flags", {27'd0, ld_valid, adel, ades, bus_err, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    expect_req(32'h0000_1000, 4'b1111, 1'b0, 32'h0);
    expect_ld(32'hDEAD_BEEF, 2'd0);
    issue(OP_LW, 32'h0000_1000, 32'h0, 3, 32'hDEAD_BEEF, 4);

    expect_req(32'h0000_2000, 4'b1000, 1'b1, 32'hA5A5_A5A5);
    issue(OP_SB, 32'h0000_2003, 32'h0000_00A5, 1, 32'h0, 2);
    chk("ld_data_hold", ld_data, last_ld);

    expect_req(32'h0000_2000, 4'b1100, 1'b1, 32'h1234_1234);
    issue(OP_SH, 32'h0000_2002, 32'h0000_1234, 2, 32'h0, 3);

    q_exc.push_back(2'b01);
    issue(OP_SH, 32'h0000_2001, 32'h0000_1234, 1, 32'h0, 0);

    expect_req(32'h0000_3000, 4'b1111, 1'b0, 32'h0);
    expect_ld(32'hCAFE_F00D, 2'd2);
    issue(OP_LHU, 32'h0000_3002, 32'h0, 1, 32'hCAFE_F00D, 2);

    q_exc.push_back(2'b10);
    issue(OP_LW, 32'h0000_3001, 32'h0, 1, 32'h0, 0);

    issue(OP_ADD, 32'h0000_3001, 32'h0, 1, 32'h0, 0);

    expect_req(32'h0000_4000, 4'b1111, 1'b1, 32'h89AB_CDEF);
    issue(OP_SW, 32'h0000_4000, 32'h89AB_CDEF, 2, 32'h0, 3);

    expect_req(32'h0000_5000, 4'b1111, 1'b0, 32'h0);
    expect_ld(32'h1122_3344, 2'd1);
    issue(OP_LB, 32'h0000_5001, 32'h0, 1, 32'h1122_3344, 2);

    expect_req(32'h0000_6000, 4'b0010, 1'b1, 32'h3C3C_3C3C);
    issue(OP_SB, 32'h0000_6001, 32'hFFFF_FF3C, 1, 32'h0, 2);

    expect_req(32'h0000_6000, 4'b0011, 1'b1, 32'h5678_5678);
    issue(OP_SH, 32'h0000_6000, 32'hABCD_5678, 1, 32'h0, 2);
    chk("ld_data_hold2", ld_data, last_ld);

    q_exc.push_back(2'b10);
    issue(OP_LH, 32'h0000_7003, 32'h0, 1, 32'h0, 0);

    expect_req(32'h0000_7000, 4'b1111, 1'b0, 32'h0);
    expect_ld(32'h0000_0000, 2'd3);
    issue(OP_LBU, 32'h0000_7003, 32'h0, 1, 32'h0, 2);

    q_exc.push_back(2'b01);
    issue(OP_SW, 32'h0000_7002, 32'h0, 1, 32'h0, 0);

`ifdef LSU_TIMEOUT_EN
    expect_req(32'h0000_9000, 4'b1111, 1'b0, 32'h0);
    q_berr++;
    issue(OP_LW, 32'h0000_9000, 32'h0, 0, 32'h0, 16);
    @(negedge clk);
    chk("berr_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
    chk("berr_no_ld_valid", {31'd0, ld_valid}, 32'd0);
    expect_req(32'h0000_9004, 4'b1111, 1'b0, 32'h0);
    expect_ld(32'h0BAD_F00D, 2'd0);
    issue(OP_LW, 32'h0000_9004, 32'h0, 1, 32'h0BAD_F00D, 2);
`endif

    // Reset in the middle of an access, followed by a stale ack.
    expect_req(32'h0000_8000, 4'b1111, 1'b0, 32'h0);
    @(posedge clk); #1;
    ack_after = 0;
    req_valid = 1'b1;
    ir_m      = {OP_LW, 26'h0};
    addr      = 32'h0000_8000;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (bus.mem_req) seen = 1'b1;
      end
      chk("rst_test_req_seen", {31'd0, seen}, 32'd1);
    end
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    ir_m      = '0;
    @(posedge clk); #1;
    reset     = 1'b0;
    stale_ack = 1'b1;
    rdata_drv = 32'h5555_AAAA;
    @(negedge clk);
    chk("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    stale_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'd0, bus.mem_req, stall, ld_valid}, 32'd0);
    end
    chk("post_rst_ld_data", ld_data, 32'd0);

    repeat (3) @(posedge clk);
    chk("q_req_drained", 32'(q_req.size()), 32'd0);
    chk("q_ld_drained", 32'(q_ld.size()), 32'd0);
    chk("q_exc_drained", 32'(q_exc.size()), 32'd0);
    chk("q_berr_drained", 32'(q_berr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
